// File: rtl/audio_dac_stream_out.sv
// Stereo DAC streamer: per-channel sample FIFOs feed an I2S / left-justified serialiser on AUD_DACDAT.
// AUD_DACDAT lags a pin BCLK fall by 3 clk; a channel's ready drops only while its FIFO is full.

// Single-clock FIFO with combinational head and full/empty derived from the occupancy count.
module audio_dac_stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == FULL_LVL);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
    else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module audio_dac_stream_out #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT,
  input  logic [DATA_WIDTH-1:0]       to_dac_left_channel_data,
  input  logic                        to_dac_left_channel_valid,
  output logic                        to_dac_left_channel_ready,
  input  logic [DATA_WIDTH-1:0]       to_dac_right_channel_data,
  input  logic                        to_dac_right_channel_valid,
  output logic                        to_dac_right_channel_ready,
  input  logic                        mute,
  output logic [$clog2(FIFO_DEPTH):0] left_level,
  output logic [$clog2(FIFO_DEPTH):0] right_level,
  output logic [7:0]                  underrun_count,
  input  logic                        underrun_clear
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);

  logic                  bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic                  lrck_s1_q, lrck_s2_q, lrck_q, lrck_d;
  logic                  bclk_fall, boundary;
  logic [DATA_WIDTH-1:0] l_head, r_head, sel_head, load_word;
  logic                  l_empty, r_empty, l_full, r_full, sel_empty, underrun;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  dat_q, dat_d;
  logic [7:0]            undr_q, undr_d;

  assign bclk_fall = bclk_s3_q && !bclk_s2_q;
  assign boundary  = bclk_fall && (lrck_s2_q != lrck_q);
  assign sel_empty = lrck_s2_q ? r_empty : l_empty;
  assign sel_head  = lrck_s2_q ? r_head : l_head;
  // Muted loads still consume the queued word so the FIFO keeps draining in step with the codec.
  assign load_word = (mute || sel_empty) ? '0 : sel_head;
  assign underrun  = boundary && sel_empty && !mute;

  audio_dac_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_left_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (to_dac_left_channel_valid),
    .push_dat_i (to_dac_left_channel_data),
    .pop_i      (boundary && !lrck_s2_q),
    .head_dat_o (l_head),
    .empty_o    (l_empty),
    .full_o     (l_full),
    .level_o    (left_level)
  );

  audio_dac_stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_right_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (to_dac_right_channel_valid),
    .push_dat_i (to_dac_right_channel_data),
    .pop_i      (boundary && lrck_s2_q),
    .head_dat_o (r_head),
    .empty_o    (r_empty),
    .full_o     (r_full),
    .level_o    (right_level)
  );

  assign to_dac_left_channel_ready  = !l_full;
  assign to_dac_right_channel_ready = !r_full;
  assign AUD_DACDAT                 = dat_q;
  assign underrun_count             = undr_q;

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    dat_d  = dat_q;
    lrck_d = bclk_fall ? lrck_s2_q : lrck_q;
    if (boundary) begin
      if (MODE == 1) begin
        dat_d  = load_word[DATA_WIDTH-1];
        sreg_d = load_word << 1;
        cnt_d  = CW'(1);
      end else begin
        dat_d  = 1'b0;
        sreg_d = load_word;
        cnt_d  = '0;
      end
    end else if (bclk_fall) begin
      if (cnt_q < CNT_MAX) begin
        dat_d  = sreg_q[DATA_WIDTH-1];
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q + CW'(1);
      end else begin
        dat_d = 1'b0;
      end
    end
  end

  always_comb begin
    undr_d = undr_q;
    if (underrun_clear)                  undr_d = '0;
    else if (underrun && undr_q != 8'hFF) undr_d = undr_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_q    <= 1'b0;
      sreg_q    <= '0;
      cnt_q     <= CNT_MAX;
      dat_q     <= 1'b0;
      undr_q    <= '0;
    end else begin
      bclk_s1_q <= AUD_BCLK;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lrck_s1_q <= AUD_DACLRCK;
      lrck_s2_q <= lrck_s1_q;
      lrck_q    <= lrck_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      dat_q     <= dat_d;
      undr_q    <= undr_d;
    end
  end
endmodule

// File: tb/tb_audio_dac_stream_out.sv
// Two instances share the codec clocks: 16-bit/depth-4/I2S and 24-bit/depth-8/left-justified.
module tb_audio_dac_stream_out;
  logic        clk = 1'b0, reset_n = 1'b0, bclk = 1'b1, lrck = 1'b0, mute = 1'b0, uclr = 1'b0;
  logic        dat0, dat1;
  logic [15:0] l_dat0 = '0, r_dat0 = '0;
  logic [23:0] l_dat1 = '0, r_dat1 = '0;
  logic        l_vld0 = 1'b0, r_vld0 = 1'b0, l_vld1 = 1'b0, r_vld1 = 1'b0;
  logic        l_rdy0, r_rdy0, l_rdy1, r_rdy1;
  logic [2:0]  l_lvl0, r_lvl0;
  logic [3:0]  l_lvl1, r_lvl1;
  logic [7:0]  undr0, undr1;

  always #5 clk = ~clk;

  audio_dac_stream_out #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat0),
    .to_dac_left_channel_data(l_dat0), .to_dac_left_channel_valid(l_vld0),
    .to_dac_left_channel_ready(l_rdy0), .to_dac_right_channel_data(r_dat0),
    .to_dac_right_channel_valid(r_vld0), .to_dac_right_channel_ready(r_rdy0),
    .mute(mute), .left_level(l_lvl0), .right_level(r_lvl0),
    .underrun_count(undr0), .underrun_clear(uclr));

  audio_dac_stream_out #(.DATA_WIDTH(24), .FIFO_DEPTH(8), .MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .AUD_BCLK(bclk), .AUD_DACLRCK(lrck), .AUD_DACDAT(dat1),
    .to_dac_left_channel_data(l_dat1), .to_dac_left_channel_valid(l_vld1),
    .to_dac_left_channel_ready(l_rdy1), .to_dac_right_channel_data(r_dat1),
    .to_dac_right_channel_valid(r_vld1), .to_dac_right_channel_ready(r_rdy1),
    .mute(mute), .left_level(l_lvl1), .right_level(r_lvl1),
    .underrun_count(undr1), .underrun_clear(uclr));

  int total = 0, bad = 0;

  // Reference model: sample queues per (dut, channel), word currently on the wire, underrun counts.
  logic [31:0] mq [4][$];
  logic [31:0] cur_w [2];
  int          undr_m [2];
  logic        last_exp [2];
  bit          lr_m = 1'b0;

  typedef struct {
    int          len;
    logic [31:0] e0;
    logic [31:0] e1;
    int          u0;
    int          u1;
  } vec_t;
  vec_t tbl [8];

  function automatic int dw(input int d);    return (d == 0) ? 16 : 24; endfunction
  function automatic int depth(input int d); return (d == 0) ? 4 : 8;   endfunction
  function automatic int mode(input int d);  return (d == 0) ? 0 : 1;   endfunction

  function automatic logic dac(input int d); return (d == 0) ? dat0 : dat1; endfunction
  function automatic logic [31:0] undr(input int d); return (d == 0) ? 32'(undr0) : 32'(undr1); endfunction
  function automatic logic [31:0] lvl(input int d, input int ch);
    case (d * 2 + ch)
      0: return 32'(l_lvl0);
      1: return 32'(r_lvl0);
      2: return 32'(l_lvl1);
      default: return 32'(r_lvl1);
    endcase
  endfunction
  function automatic logic rdy(input int d, input int ch);
    case (d * 2 + ch)
      0: return l_rdy0;
      1: return r_rdy0;
      2: return l_rdy1;
      default: return r_rdy1;
    endcase
  endfunction

  // Bit k of a slot (k=0 is the boundary fall): I2S delays the MSB by one bit, left-justified does not.
  function automatic logic exp_bit(input int d, input int k);
    int w = dw(d);
    if (mode(d) == 0) begin
      if (k >= 1 && k <= w) return cur_w[d][w - k];
    end else begin
      if (k < w) return cur_w[d][w - 1 - k];
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_boundary(input bit mv, input bit clr);
    for (int d = 0; d < 2; d++) begin
      int q = d * 2 + int'(lr_m);
      if (mq[q].size() == 0) begin
        cur_w[d] = '0;
        if (!mv && undr_m[d] < 255) undr_m[d]++;
      end else begin
        logic [31:0] w = mq[q].pop_front();
        cur_w[d] = mv ? 32'h0 : w;
      end
      if (clr) undr_m[d] = 0;
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 4; q++) mq[q].delete();
    for (int d = 0; d < 2; d++) begin
      cur_w[d] = '0; undr_m[d] = 0; last_exp[d] = 1'b0;
    end
    lr_m = 1'b0;
  endtask

  task automatic push(input int d, input int ch, input logic [31:0] w);
    logic [31:0] m = (d == 0) ? 32'h0000_FFFF : 32'h00FF_FFFF;
    int  q = d * 2 + ch;
    bit  exp_rdy = (mq[q].size() < depth(d));
    case (q)
      0: begin l_dat0 = w[15:0]; l_vld0 = 1'b1; end
      1: begin r_dat0 = w[15:0]; r_vld0 = 1'b1; end
      2: begin l_dat1 = w[23:0]; l_vld1 = 1'b1; end
      default: begin r_dat1 = w[23:0]; r_vld1 = 1'b1; end
    endcase
    chk("push_ready", 32'(rdy(d, ch)), 32'(exp_rdy));
    #10;
    l_vld0 = 1'b0; r_vld0 = 1'b0; l_vld1 = 1'b0; r_vld1 = 1'b0;
    if (exp_rdy) mq[q].push_back(w & m);
  endtask

  task automatic end_checks();
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk("level", lvl(d, ch), 32'(mq[d * 2 + ch].size()));
        chk("ready", 32'(rdy(d, ch)), 32'(mq[d * 2 + ch].size() < depth(d)));
      end
      chk("underrun_count", undr(d), 32'(undr_m[d]));
    end
  endtask

  // BCLK bits idle at the current LRCK level, before any boundary has been seen.
  task automatic idle_bclk(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      bclk = 1'b0; #40; bclk = 1'b1; #38;
      chk(tag, 32'(dat0), 32'h0);
      chk(tag, 32'(dat1), 32'h0);
      #2;
    end
  endtask

  // One slot of len BCLK periods (80 ns each); LRCK toggles on its first falling edge.
  task automatic run_slot(input int len, input bit mv, input bit clr, input bit lat,
                          output logic [31:0] cap0, output logic [31:0] cap1);
    int   pre_lvl [2];
    logic e;
    cap0 = '0; cap1 = '0;
    mute = mv;
    for (int k = 0; k < len; k++) begin
      bclk = 1'b0;
      if (k == 0) begin
        lr_m = ~lr_m;
        lrck = lr_m;
        for (int d = 0; d < 2; d++) pre_lvl[d] = mq[d * 2 + int'(lr_m)].size();
        model_boundary(mv, clr);
      end
      #10; if (k == 0 && clr) uclr = 1'b1;
      #11;
      if (k == 0 && lat) for (int d = 0; d < 2; d++) begin
        chk("latency_before_dat", 32'(dac(d)), 32'(last_exp[d]));
        chk("latency_before_level", lvl(d, int'(lr_m)), 32'(pre_lvl[d]));
      end
      #4;
      if (k == 0 && lat) for (int d = 0; d < 2; d++) begin
        chk("latency_after_dat", 32'(dac(d)), 32'(exp_bit(d, 0)));
        chk("latency_after_level", lvl(d, int'(lr_m)), 32'(mq[d * 2 + int'(lr_m)].size()));
      end
      #5; uclr = 1'b0;
      #10; bclk = 1'b1;
      #38;
      for (int d = 0; d < 2; d++) begin
        e = exp_bit(d, k);
        chk("serial_bit", 32'(dac(d)), 32'(e));
        last_exp[d] = e;
      end
      if (k < 32) begin
        cap0[31 - k] = dat0;
        cap1[31 - k] = dat1;
      end
      #2;
    end
    end_checks();
  endtask

  initial begin
    logic [31:0] c0, c1;
    tbl[0] = '{32, 32'h091A_0000, 32'h1234_5600, 0, 0};
    tbl[1] = '{32, 32'h52E1_8000, 32'h8000_0100, 0, 0};
    tbl[2] = '{8,  32'h5F00_0000, 32'hAB00_0000, 0, 0};
    tbl[3] = '{8,  32'h6000_0000, 32'h5A00_0000, 0, 0};
    tbl[4] = '{32, 32'h4000_8000, 32'hFFFF_FF00, 0, 0};
    tbl[5] = '{32, 32'h0,         32'h0,         1, 1};
    tbl[6] = '{32, 32'h0,         32'h0,         2, 2};
    tbl[7] = '{32, 32'h0,         32'h0,         3, 3};
    model_reset();

    // Reset held with BCLK running.
    #2;
    idle_bclk(3, "reset_dacdat");
    end_checks();
    reset_n = 1'b1;
    #10;
    idle_bclk(2, "pre_boundary_dacdat");

    push(0, 1, 32'h1234); push(0, 1, 32'hBEEF); push(0, 1, 32'h8001);
    push(0, 0, 32'hA5C3); push(0, 0, 32'hC0DE);
    push(1, 1, 32'h123456); push(1, 1, 32'hABCDEF); push(1, 1, 32'hFFFFFF);
    push(1, 0, 32'h800001); push(1, 0, 32'h5A5A5A);

    for (int i = 0; i < 8; i++) begin
      run_slot(tbl[i].len, 1'b0, 1'b0, i == 1, c0, c1);
      chk("table_slot_dut0", c0, tbl[i].e0);
      chk("table_slot_dut1", c1, tbl[i].e1);
      chk("table_underrun_dut0", undr(0), 32'(tbl[i].u0));
      chk("table_underrun_dut1", undr(1), 32'(tbl[i].u1));
    end

    // Clear coinciding with an underrun.
    run_slot(16, 1'b0, 1'b1, 1'b0, c0, c1);
    chk("clear_wins_dut0", undr(0), 32'h0);
    chk("clear_wins_dut1", undr(1), 32'h0);

    // Mute with words queued on the left.
    push(0, 0, 32'h7FFF); push(1, 0, 32'h7FFFFF);
    run_slot(32, 1'b1, 1'b0, 1'b0, c0, c1);
    chk("mute_bits_dut0", c0, 32'h0);
    chk("mute_bits_dut1", c1, 32'h0);
    chk("mute_level_dut0", lvl(0, 0), 32'h0);
    chk("mute_count_dut0", undr(0), 32'h0);

    // Backpressure on the depth-4 left FIFO, then one left boundary.
    for (int i = 1; i <= 6; i++) push(0, 0, 32'h1111 * i);
    chk("full_level", lvl(0, 0), 32'd4);
    chk("full_ready", 32'(l_rdy0), 32'h0);
    push(1, 0, 32'h800001);
    run_slot(8, 1'b1, 1'b0, 1'b0, c0, c1);
    run_slot(32, 1'b0, 1'b0, 1'b1, c0, c1);
    chk("drain_level", lvl(0, 0), 32'd3);
    chk("drain_ready", 32'(l_rdy0), 32'h1);
    chk("drain_bits_dut0", c0, 32'h0888_8000);
    chk("lj24_bits_dut1", c1, 32'h8000_0100);

    // Randomised traffic against the model.
    for (int r = 0; r < 40; r++) begin
      int np = $urandom_range(0, 5);
      int ns = $urandom_range(1, 3);
      for (int p = 0; p < np; p++)
        push($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      for (int s = 0; s < ns; s++)
        run_slot($urandom_range(6, 36), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 1'b1, c0, c1);
    end

    // Asynchronous reset while the 24-bit instance is driving a 1.
    if (lr_m) run_slot(8, 1'b1, 1'b0, 1'b0, c0, c1);
    push(1, 1, 32'hFFFFFF);
    push(0, 0, 32'h4321);
    run_slot(8, 1'b0, 1'b0, 1'b0, c0, c1);
    chk("before_reset_dat1", 32'(dat1), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_dat1", 32'(dat1), 32'h0);
    model_reset();
    lrck = 1'b0;
    end_checks();
    #9;
    reset_n = 1'b1;
    #10;
    run_slot(8, 1'b0, 1'b0, 1'b0, c0, c1);
    chk("resume_underrun_dut0", undr(0), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_dac_stream_out.md
# audio_dac_stream_out

Parametrised DAC-side audio streaming block: accepts left/right PCM samples from the system on valid/ready handshakes, buffers each channel in its own FIFO, and serialises them onto AUD_DACDAT in the codec's bit clock/LR clock framing. It supersedes the fixed 16-bit stereo codec interface with configurable sample width, buffer depth and framing mode, underrun handling, mute, and fill/underrun status. It sits between the sound mixer and the codec pins, in the `clk` domain, with AUD_BCLK and AUD_DACLRCK treated as asynchronous inputs.

## Interface
- DATA_WIDTH, 16, sample width in bits (8..32).
- FIFO_DEPTH, 8, entries per channel FIFO (power of 2, 2..64).
- MODE, 0, framing: 0 = I2S (one-BCLK MSB delay), 1 = left-justified (no delay).
- clk  in  1  system clock; must be ≥ 4× AUD_BCLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock, asynchronous to clk.
- AUD_DACLRCK  in  1  codec LR clock, asynchronous; low = left, high = right.
- AUD_DACDAT  out  1  serial DAC data.
- to_dac_left_channel_data  in  DATA_WIDTH  left sample, two's complement.
- to_dac_left_channel_valid  in  1  left sample present.
- to_dac_left_channel_ready  out  1  left FIFO not full.
- to_dac_right_channel_data / _valid / _ready  as left, right channel.
- mute  in  1  force zero samples onto the wire (FIFOs still drain).
- left_level, right_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- underrun_count  out  8  saturating count of empty-FIFO sample loads, both channels.
- underrun_clear  in  1  synchronous clear of underrun_count.

## Operation
- AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchroniser; BCLK falling edge detected from synchronised value (one-cycle strobe `bclk_fall`).
- LRCK is sampled only on `bclk_fall`; a difference from the previously sampled value is a channel boundary.
- On a channel boundary: pop one word from the FIFO for the new channel (LRCK 0 → left, 1 → right) into a DATA_WIDTH shift register; bit counter cleared.
- Empty FIFO at boundary: load zero, no pop, underrun_count +1 (saturates at 255). Mute: load zero, pop still occurs if non-empty, no underrun counted.
- Shift: MODE=0: on boundary strobe output 0, MSB on next `bclk_fall`; MODE=1: MSB output on the boundary strobe itself. Each subsequent `bclk_fall` shifts next bit. After DATA_WIDTH bits, output 0 until next boundary.
- Boundary arriving before all bits sent (slot shorter than DATA_WIDTH): truncate, reload immediately.
- FIFO push: valid && ready on rising clk. ready = !full (combinational from level). Push and pop same cycle: both take effect, level unchanged; push to full FIFO impossible (ready low); pop from empty handled as underrun, simultaneous push still stored.
- underrun_clear and a simultaneous underrun: clear wins, count = 0.
- First boundary after reset is the first channel load; no output before it.

## Timing
- Reset values: AUD_DACDAT 0, both ready 1, levels 0, underrun_count 0, shift register 0, sampled LRCK 0, synchronisers 0.
- reset_n assertion mid-frame: FIFOs emptied and AUD_DACDAT 0 immediately (asynchronous); resumes at next detected boundary after release.
- Pin BCLK falling edge → AUD_DACDAT update: 3 clk cycles (2 sync + 1 edge detect/output register); AUD_DACDAT registered, changes only on `bclk_fall` cycles.
- Push → level increment and ready update: 1 clk. Pop → level decrement: 1 clk.
- Sample write → first bit on wire: at earliest the next channel boundary of that channel.

## Test plan
- Reset: hold reset_n low with BCLK running → AUD_DACDAT 0, ready 1, levels 0; release → nothing driven until first LRCK edge.
- I2S left/right: DATA_WIDTH=16, MODE=0, push L=0xA5C3, R=0x1234, 32 BCLK per frame → wire shows 0 then A5C3 MSB-first in left slot, 0 then 1234 in right slot, zeros after bit 16.
- Left-justified 24-bit: MODE=1, DATA_WIDTH=24, L=0x800001 → MSB on boundary bit, 24 bits, then zeros; verify 3-clk pin latency.
- Backpressure: FIFO_DEPTH=4, push 6 left samples with no BCLK → 4 accepted, ready low, left_level=4; one boundary → level 3, ready high next clk.
- Underrun/mute: no data for 3 left slots → zeros on wire, underrun_count=3; underrun_clear with simultaneous underrun → 0; mute with L=0x7FFF queued → zeros sent, level drops, count unchanged.
- Short slot: 8 BCLK per slot, DATA_WIDTH=16 → first 8 bits (MODE=0: 7 bits) sent, next word loads at boundary without corruption.
